// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and sizes for the register-file writeback controller.
// Holds no logic, so it adds no latency.
// Holds no logic, so it has no backpressure.
package regfile_wb_ctrl_pkg;
  localparam int REG_AW    = 4;
  localparam int REG_DW    = 32;
  localparam int REG_COUNT = 16;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [REG_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Writeback, register-file and operand signals between execute, the controller and the file.
// Carries signals only, so it adds no latency.
// Writeback uses valid/ready; the file side and operand fetch have no backpressure.
interface regfile_wb_ctrl_if #(parameter int DEPTH = regfile_wb_ctrl_pkg::WB_DEPTH);
  import regfile_wb_ctrl_pkg::*;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_AW-1:0]     wb_rd;
  logic [REG_DW-1:0]     wb_data;
  logic                  rf_we_n;
  logic [REG_AW-1:0]     rf_waddr;
  logic [REG_DW-1:0]     rf_wdata;
  logic                  rd_valid;
  logic [REG_AW-1:0]     rd_ra;
  logic [REG_AW-1:0]     rd_rb;
  logic [REG_AW-1:0]     rf_ra;
  logic [REG_AW-1:0]     rf_rb;
  logic [REG_DW-1:0]     rf_a;
  logic [REG_DW-1:0]     rf_b;
  logic                  op_valid;
  logic [REG_DW-1:0]     op_a;
  logic [REG_DW-1:0]     op_b;
  logic [$clog2(DEPTH):0] pending;

  // Environment side: execute stage, register file and operand consumer.
  modport master (
    output wb_valid, wb_rd, wb_data, rd_valid, rd_ra, rd_rb, rf_a, rf_b,
    input  wb_ready, rf_we_n, rf_waddr, rf_wdata, rf_ra, rf_rb, op_valid, op_a, op_b, pending
  );

  // Controller side.
  modport slave (
    input  wb_valid, wb_rd, wb_data, rd_valid, rd_ra, rd_rb, rf_a, rf_b,
    output wb_ready, rf_we_n, rf_waddr, rf_wdata, rf_ra, rf_rb, op_valid, op_a, op_b, pending
  );
endinterface

// File: rtl/regfile_wb_fifo.sv
// Writeback FIFO with a two-port youngest-match search over all occupied entries.
// An entry is visible to lookups from the cycle after its push; lookups are combinational.
// The caller must not push when full or pop when empty.
module regfile_wb_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  wb_entry_t              push_dat,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic [REG_AW-1:0]      look_a,
  input  logic [REG_AW-1:0]      look_b,
  output logic                   hit_a,
  output logic                   hit_b,
  output logic [REG_DW-1:0]      dat_a,
  output logic [REG_DW-1:0]      dat_b
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Next storage/pointer/count state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk occupied entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] ptr;
    ptr   = rd_ptr_q;
    hit_a = 1'b0;
    hit_b = 1'b0;
    dat_a = '0;
    dat_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ptr = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (mem_q[ptr].idx == look_a) begin
          hit_a = 1'b1;
          dat_a = mem_q[ptr].data;
        end
        if (mem_q[ptr].idx == look_b) begin
          hit_b = 1'b1;
          dat_b = mem_q[ptr].data;
        end
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Buffers writebacks into the register file and serves bypassed two-operand reads.
// Writes retire the cycle after acceptance; operands appear one cycle after the request.
// wb_ready is !full from registered state only; retirement and reads never stall.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic              clk,
  input logic              clr,
  regfile_wb_ctrl_if.slave bus
);
  wb_entry_t              push_dat;
  wb_entry_t              head;
  logic                   push, retire, empty, full;
  logic                   hit_a, hit_b;
  logic [REG_DW-1:0]      byp_a, byp_b;
  logic [$clog2(DEPTH):0] count;
  logic                   op_valid_q, op_valid_d;
  logic [REG_DW-1:0]      op_a_q, op_a_d;
  logic [REG_DW-1:0]      op_b_q, op_b_d;

  assign push_dat     = '{idx: bus.wb_rd, data: bus.wb_data};
  assign bus.wb_ready = ~full;
  assign push         = bus.wb_valid & ~full;
  // No retire during a clear cycle, so a discarded write can never reach the file.
  assign retire       = ~empty & clr;
  assign bus.pending  = count;
  assign bus.rf_ra    = bus.rd_ra;
  assign bus.rf_rb    = bus.rd_rb;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .push     (push),
    .push_dat (push_dat),
    .pop      (retire),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .look_a   (bus.rd_ra),
    .look_b   (bus.rd_rb),
    .hit_a    (hit_a),
    .hit_b    (hit_b),
    .dat_a    (byp_a),
    .dat_b    (byp_b)
  );

  // Drive the file write port straight from the FIFO head; idle values are zero.
  always_comb begin
    bus.rf_we_n  = 1'b1;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (retire) begin
      bus.rf_we_n  = 1'b0;
      bus.rf_waddr = head.idx;
      bus.rf_wdata = head.data;
    end
  end

  // Resolve operands: youngest pending write wins over the file, otherwise hold.
  always_comb begin
    op_valid_d = bus.rd_valid;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (bus.rd_valid) begin
      op_a_d = hit_a ? byp_a : bus.rf_a;
      op_b_d = hit_b ? byp_b : bus.rf_b;
    end
  end

  // Operand registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios followed by random traffic and random clears.
// Reads are compared one cycle after they are issued.
// The bench drives writeback valid and reacts to wb_ready; the file model has no stall.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr;
  logic preload;
  int   checks   = 0;
  int   failures = 0;

  logic [REG_DW-1:0] file_mem  [REG_COUNT];
  logic [REG_DW-1:0] seed_mem  [REG_COUNT];
  logic [REG_DW-1:0] filemodel [REG_COUNT];
  wb_entry_t         q[$];
  bit                model_ok = 1'b0;
  logic              exp_opv;
  logic [REG_DW-1:0] exp_a, exp_b;

  regfile_wb_ctrl_if #(.DEPTH(DEPTH)) ifc ();

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // The register file itself: two combinational reads, write on a low enable.
  assign ifc.rf_a = file_mem[ifc.rf_ra];
  assign ifc.rf_b = file_mem[ifc.rf_rb];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < REG_COUNT; i++) file_mem[i] <= seed_mem[i];
    end else if (ifc.rf_we_n === 1'b0) begin
      file_mem[ifc.rf_waddr] <= ifc.rf_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Program-order value of a register: file contents with every accepted write applied in order.
  function automatic logic [31:0] resolve(input logic [3:0] idx);
    logic [31:0] v;
    v = filemodel[idx];
    foreach (q[k]) if (q[k].idx == idx) v = q[k].data;
    return v;
  endfunction

  // One clock cycle: apply inputs after the falling edge, check, clock, update the model, check operands.
  task automatic cycle(input logic clr_v, input logic wv, input logic [3:0] wrd, input logic [31:0] wdat,
                       input logic rv, input logic [3:0] ra, input logic [3:0] rb);
    logic        acc;
    logic [31:0] ea, eb;
    wb_entry_t   e;
    clr          = clr_v;
    ifc.wb_valid = wv;
    ifc.wb_rd    = wrd;
    ifc.wb_data  = wdat;
    ifc.rd_valid = rv;
    ifc.rd_ra    = ra;
    ifc.rd_rb    = rb;
    #1;
    if (model_ok) begin
      chk("wb_ready", {31'b0, ifc.wb_ready}, {31'b0, q.size() < DEPTH});
      chk("pending", 32'(ifc.pending), 32'(q.size()));
      chk("rf_we_n", {31'b0, ifc.rf_we_n}, {31'b0, !(clr_v && q.size() > 0)});
      chk("rf_waddr", 32'(ifc.rf_waddr), (clr_v && q.size() > 0) ? 32'(q[0].idx) : 32'd0);
      chk("rf_wdata", ifc.rf_wdata, (clr_v && q.size() > 0) ? q[0].data : 32'd0);
    end
    chk("rf_ra", 32'(ifc.rf_ra), 32'(ra));
    chk("rf_rb", 32'(ifc.rf_rb), 32'(rb));
    acc = wv && (q.size() < DEPTH);
    ea  = resolve(ra);
    eb  = resolve(rb);
    @(posedge clk);
    if (!clr_v) begin
      q.delete();
      exp_opv  = 1'b0;
      exp_a    = '0;
      exp_b    = '0;
      model_ok = 1'b1;
    end else begin
      if (q.size() > 0) begin
        filemodel[q[0].idx] = q[0].data;
        void'(q.pop_front());
      end
      if (acc) begin
        e.idx  = wrd;
        e.data = wdat;
        q.push_back(e);
      end
      exp_opv = rv;
      if (rv) begin
        exp_a = ea;
        exp_b = eb;
      end
    end
    @(negedge clk);
    if (model_ok) begin
      chk("op_valid", {31'b0, ifc.op_valid}, {31'b0, exp_opv});
      chk("op_a", ifc.op_a, exp_a);
      chk("op_b", ifc.op_b, exp_b);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    clr          = 1'b0;
    ifc.wb_valid = 1'b0;
    ifc.wb_rd    = '0;
    ifc.wb_data  = '0;
    ifc.rd_valid = 1'b0;
    ifc.rd_ra    = '0;
    ifc.rd_rb    = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      seed_mem[i]  = $urandom;
      filemodel[i] = seed_mem[i];
    end
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    // Clear held for two cycles while a writeback is offered.
    cycle(1'b0, 1'b1, 4'd9, 32'h1234_5678, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 1'b1, 4'd9, 32'h1234_5678, 1'b0, 4'd0, 4'd0);
    idle(1);

    // Single write, then read it back from the file.
    cycle(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd0);
    chk("t2_op_a", ifc.op_a, 32'hDEAD_BEEF);

    // Back-to-back pushes R1..R5 with continuous drain.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 4'd0);
    idle(2);
    for (int i = 1; i <= 5; i++) chk("t3_file", file_mem[i], 32'h100 + 32'(i));

    // Two writes to R5, read both operands from R5 while the younger is pending, then R6.
    cycle(1'b1, 1'b1, 4'd5, 32'h11, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd5, 32'h22, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd5);
    chk("t4_op_a", ifc.op_a, 32'h22);
    chk("t4_op_b", ifc.op_b, 32'h22);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd6);

    // Push and read of R7 on the same edge, then again a cycle later.
    cycle(1'b1, 1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 4'd2);
    cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'd7);
    chk("t5_op_a", ifc.op_a, 32'h77);

    // Clear while writes are in flight: the pending ones must never reach the file.
    cycle(1'b1, 1'b1, 4'd10, 32'hA0, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd11, 32'hB0, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b1, 4'd12, 32'hC0, 1'b1, 4'd12, 4'd11);
    cycle(1'b0, 1'b1, 4'd13, 32'hD0, 1'b0, 4'd0, 4'd0);
    idle(3);
    chk("t6_r12", file_mem[12], filemodel[12]);

    // Random traffic with occasional clears; narrow index range raises bypass hits.
    for (int n = 0; n < 400; n++) begin
      logic       c, wv, rv;
      logic [3:0] wrd, ra, rb;
      c   = ($urandom_range(0, 63) != 0);
      wv  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      wrd = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      ra  = 4'($urandom_range(0, 3));
      rb  = 4'($urandom_range(0, 15));
      cycle(c, wv, wrd, $urandom, rv, ra, rb);
    end
    idle(4);
    for (int i = 0; i < REG_COUNT; i++) chk("final_file", file_mem[i], filemodel[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
